// File: rtl/id_stage_ctrl.sv
// id_stage_ctrl: decode-stage controller for the 5-stage pipeline.
// Decodes the IF/ID instruction into the immediate-format select and the
// control bundle for EX. It also detects load-use hazards, which stall the
// PC and IF/ID, and it owns the ID/EX control register. That register handles
// bubble insertion and the mispredict flush. Saturating counters record stall
// cycles and illegal issues.
//
// Ports:
//   i_clk, i_rst_n      clock (rising edge), async active-low reset
//   i_instr, i_id_valid IF/ID instruction and its valid bit
//   i_flush             EX redirect; squash ID this cycle
//   i_cnt_clr           synchronous clear of both counters
//   o_imm_src           combinational immediate-format select
//   o_stall             combinational load-use stall (PC + IF/ID hold)
//   o_ex_*              registered ID/EX control bundle
//   o_stall_cnt         saturating count of stall cycles
//   o_illegal_cnt       saturating count of illegal instructions issued
module id_stage_ctrl #(
  parameter int CNT_W = 16
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [31:0]      i_instr,
  input  logic             i_id_valid,
  input  logic             i_flush,
  input  logic             i_cnt_clr,
  output logic [2:0]       o_imm_src,
  output logic             o_stall,
  output logic             o_ex_valid,
  output logic [4:0]       o_ex_rd,
  output logic [4:0]       o_ex_rs1,
  output logic [4:0]       o_ex_rs2,
  output logic             o_ex_reg_wen,
  output logic             o_ex_mem_ren,
  output logic             o_ex_mem_wen,
  output logic             o_ex_alu_imm,
  output logic             o_ex_branch,
  output logic             o_ex_jump,
  output logic [2:0]       o_ex_funct3,
  output logic             o_ex_illegal,
  output logic [CNT_W-1:0] o_stall_cnt,
  output logic [CNT_W-1:0] o_illegal_cnt
);

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_FENCE  = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  typedef struct packed {
    logic       valid;
    logic [4:0] rd;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       reg_wen;
    logic       mem_ren;
    logic       mem_wen;
    logic       alu_imm;
    logic       branch;
    logic       jump;
    logic [2:0] funct3;
    logic       illegal;
  } ex_t;

  logic [6:0] opc;
  logic       rs1_used, rs2_used, wr_rd, illegal;
  logic       mem_ren, mem_wen, alu_imm, branch, jump;
  logic [4:0] rd, rs1, rs2;
  logic       load_use;
  ex_t        ex_d, ex_q;
  logic [CNT_W-1:0] stall_cnt_d, stall_cnt_q, ill_cnt_d, ill_cnt_q;

  // funct7 / upper immediate bits are not needed for control decode
  logic unused_hi;
  assign unused_hi = ^i_instr[31:25];

  assign opc = i_instr[6:0];
  assign rd  = i_instr[11:7];

  always_comb begin
    o_imm_src = 3'b000;
    rs1_used  = 1'b0;
    rs2_used  = 1'b0;
    wr_rd     = 1'b0;
    mem_ren   = 1'b0;
    mem_wen   = 1'b0;
    branch    = 1'b0;
    jump      = 1'b0;
    illegal   = 1'b0;
    case (opc)
      OPC_LUI, OPC_AUIPC: begin o_imm_src = 3'b011; wr_rd = 1'b1; end
      OPC_JAL:    begin o_imm_src = 3'b100; wr_rd = 1'b1; jump = 1'b1; end
      OPC_JALR:   begin rs1_used = 1'b1; wr_rd = 1'b1; jump = 1'b1; end
      OPC_LOAD:   begin rs1_used = 1'b1; wr_rd = 1'b1; mem_ren = 1'b1; end
      OPC_OPIMM:  begin rs1_used = 1'b1; wr_rd = 1'b1; end
      OPC_STORE:  begin
        o_imm_src = 3'b001; rs1_used = 1'b1; rs2_used = 1'b1; mem_wen = 1'b1;
      end
      OPC_BRANCH: begin
        o_imm_src = 3'b010; rs1_used = 1'b1; rs2_used = 1'b1; branch = 1'b1;
      end
      OPC_OP:     begin rs1_used = 1'b1; rs2_used = 1'b1; wr_rd = 1'b1; end
      OPC_FENCE, OPC_SYSTEM: ;
      default:    begin o_imm_src = 3'b111; illegal = 1'b1; end
    endcase
  end

  // An unknown opcode has no format, so it never selects the immediate.
  assign alu_imm = ~illegal & (opc != OPC_OP) & (opc != OPC_BRANCH);

  // Unused source fields read as x0 so they can never match a load target.
  assign rs1 = rs1_used ? i_instr[19:15] : 5'd0;
  assign rs2 = rs2_used ? i_instr[24:20] : 5'd0;

  assign load_use = i_id_valid & ex_q.valid & ex_q.mem_ren & (ex_q.rd != 5'd0) &
                    ((rs1_used & (rs1 == ex_q.rd)) | (rs2_used & (rs2 == ex_q.rd)));
  // A redirect discards the dependent instruction, so holding it is pointless.
  assign o_stall  = load_use & ~i_flush;

  always_comb begin
    ex_d = '0;
    if (!i_flush && !o_stall) begin
      ex_d.valid   = i_id_valid;
      ex_d.rd      = rd;
      ex_d.rs1     = rs1;
      ex_d.rs2     = rs2;
      ex_d.funct3  = i_instr[14:12];
      ex_d.reg_wen = i_id_valid & wr_rd & (rd != 5'd0);
      ex_d.mem_ren = i_id_valid & mem_ren;
      ex_d.mem_wen = i_id_valid & mem_wen;
      ex_d.alu_imm = i_id_valid & alu_imm;
      ex_d.branch  = i_id_valid & branch;
      ex_d.jump    = i_id_valid & jump;
      ex_d.illegal = i_id_valid & illegal;
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    ill_cnt_d   = ill_cnt_q;
    if (i_cnt_clr) begin
      stall_cnt_d = '0;
      ill_cnt_d   = '0;
    end else begin
      if (o_stall && !(&stall_cnt_q))
        stall_cnt_d = stall_cnt_q + CNT_W'(1);
      if (ex_d.illegal && !(&ill_cnt_q))
        ill_cnt_d = ill_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      ex_q        <= '0;
      stall_cnt_q <= '0;
      ill_cnt_q   <= '0;
    end else begin
      ex_q        <= ex_d;
      stall_cnt_q <= stall_cnt_d;
      ill_cnt_q   <= ill_cnt_d;
    end
  end

  assign o_ex_valid    = ex_q.valid;
  assign o_ex_rd       = ex_q.rd;
  assign o_ex_rs1      = ex_q.rs1;
  assign o_ex_rs2      = ex_q.rs2;
  assign o_ex_reg_wen  = ex_q.reg_wen;
  assign o_ex_mem_ren  = ex_q.mem_ren;
  assign o_ex_mem_wen  = ex_q.mem_wen;
  assign o_ex_alu_imm  = ex_q.alu_imm;
  assign o_ex_branch   = ex_q.branch;
  assign o_ex_jump     = ex_q.jump;
  assign o_ex_funct3   = ex_q.funct3;
  assign o_ex_illegal  = ex_q.illegal;
  assign o_stall_cnt   = stall_cnt_q;
  assign o_illegal_cnt = ill_cnt_q;

endmodule

// File: tb/tb_id_stage_ctrl.sv
// Testbench for id_stage_ctrl: directed scenarios plus a randomized run, all
// checked against a behavioural model of the decode stage. A second instance
// with 2-bit counters exercises saturation.
module tb_id_stage_ctrl;

  typedef struct packed {
    logic       valid;
    logic [4:0] rd;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       reg_wen;
    logic       mem_ren;
    logic       mem_wen;
    logic       alu_imm;
    logic       branch;
    logic       jump;
    logic [2:0] funct3;
    logic       illegal;
  } ex_t;

  logic        i_clk = 1'b0;
  logic        i_rst_n = 1'b0;
  logic [31:0] i_instr = 32'h0;
  logic        i_id_valid = 1'b0, i_flush = 1'b0, i_cnt_clr = 1'b0;

  logic [2:0]  o_imm_src, o_ex_funct3;
  logic        o_stall, o_ex_valid, o_ex_reg_wen, o_ex_mem_ren, o_ex_mem_wen;
  logic        o_ex_alu_imm, o_ex_branch, o_ex_jump, o_ex_illegal;
  logic [4:0]  o_ex_rd, o_ex_rs1, o_ex_rs2;
  logic [15:0] o_stall_cnt, o_illegal_cnt;

  logic [2:0]  w2_imm_src, w2_funct3;
  logic        w2_stall, w2_valid, w2_reg_wen, w2_mem_ren, w2_mem_wen;
  logic        w2_alu_imm, w2_branch, w2_jump, w2_illegal;
  logic [4:0]  w2_rd, w2_rs1, w2_rs2;
  logic [1:0]  w2_stall_cnt, w2_illegal_cnt;

  id_stage_ctrl #(.CNT_W(16)) u_dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_instr(i_instr), .i_id_valid(i_id_valid),
    .i_flush(i_flush), .i_cnt_clr(i_cnt_clr), .o_imm_src(o_imm_src), .o_stall(o_stall),
    .o_ex_valid(o_ex_valid), .o_ex_rd(o_ex_rd), .o_ex_rs1(o_ex_rs1), .o_ex_rs2(o_ex_rs2),
    .o_ex_reg_wen(o_ex_reg_wen), .o_ex_mem_ren(o_ex_mem_ren), .o_ex_mem_wen(o_ex_mem_wen),
    .o_ex_alu_imm(o_ex_alu_imm), .o_ex_branch(o_ex_branch), .o_ex_jump(o_ex_jump),
    .o_ex_funct3(o_ex_funct3), .o_ex_illegal(o_ex_illegal),
    .o_stall_cnt(o_stall_cnt), .o_illegal_cnt(o_illegal_cnt)
  );

  id_stage_ctrl #(.CNT_W(2)) u_dut_w2 (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_instr(i_instr), .i_id_valid(i_id_valid),
    .i_flush(i_flush), .i_cnt_clr(i_cnt_clr), .o_imm_src(w2_imm_src), .o_stall(w2_stall),
    .o_ex_valid(w2_valid), .o_ex_rd(w2_rd), .o_ex_rs1(w2_rs1), .o_ex_rs2(w2_rs2),
    .o_ex_reg_wen(w2_reg_wen), .o_ex_mem_ren(w2_mem_ren), .o_ex_mem_wen(w2_mem_wen),
    .o_ex_alu_imm(w2_alu_imm), .o_ex_branch(w2_branch), .o_ex_jump(w2_jump),
    .o_ex_funct3(w2_funct3), .o_ex_illegal(w2_illegal),
    .o_stall_cnt(w2_stall_cnt), .o_illegal_cnt(w2_illegal_cnt)
  );

  always #5 i_clk = ~i_clk;

  ex_t dut_ex;
  assign dut_ex = {o_ex_valid, o_ex_rd, o_ex_rs1, o_ex_rs2, o_ex_reg_wen, o_ex_mem_ren,
                   o_ex_mem_wen, o_ex_alu_imm, o_ex_branch, o_ex_jump, o_ex_funct3,
                   o_ex_illegal};

  int total = 0;
  int bad   = 0;

  // Reference model state
  ex_t m_ex = '0;
  int  m_sc = 0, m_ic = 0, m_sc2 = 0, m_ic2 = 0;

  localparam logic [31:0] LW_X5  = 32'h0000A283;
  localparam logic [31:0] ADD_X6 = 32'h00228333;
  localparam logic [31:0] LW_X0  = 32'h0000A003;
  localparam logic [31:0] ADD_X0 = 32'h00200333;
  localparam logic [31:0] LUI_X7 = 32'h000013B7;
  localparam logic [31:0] SW_X5  = 32'h0050A023;
  localparam logic [31:0] NOP    = 32'h00000013;

  logic [31:0] fmt_ins [6] = '{32'h00A00093, 32'h00112023, 32'h00208463,
                               32'h000012B7, 32'h0080006F, 32'h00000000};
  logic [2:0]  fmt_imm [6] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd7};
  logic [6:0]  rnd_ops [13] = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h03, 7'h13, 7'h23,
                                7'h63, 7'h33, 7'h0F, 7'h73, 7'h03, 7'h7F};

  // Decode straight from the opcode table of the instruction set.
  function automatic void mdec(input logic [31:0] ins, output logic [2:0] imm,
                               output ex_t e);
    logic [6:0] op;
    bit known, u1, u2;
    op = ins[6:0];
    known = 1'b1;
    case (op)
      7'h37, 7'h17: imm = 3'd3;
      7'h6F:        imm = 3'd4;
      7'h23:        imm = 3'd1;
      7'h63:        imm = 3'd2;
      7'h67, 7'h03, 7'h13, 7'h33, 7'h0F, 7'h73: imm = 3'd0;
      default: begin imm = 3'd7; known = 1'b0; end
    endcase
    u1 = op inside {7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33};
    u2 = op inside {7'h63, 7'h23, 7'h33};
    e = '0;
    e.valid   = 1'b1;
    e.rd      = ins[11:7];
    e.rs1     = u1 ? ins[19:15] : 5'd0;
    e.rs2     = u2 ? ins[24:20] : 5'd0;
    e.funct3  = ins[14:12];
    e.reg_wen = (op inside {7'h37, 7'h17, 7'h6F, 7'h67, 7'h03, 7'h13, 7'h33}) &&
                (ins[11:7] != 5'd0);
    e.mem_ren = (op == 7'h03);
    e.mem_wen = (op == 7'h23);
    e.alu_imm = known && !(op inside {7'h33, 7'h63});
    e.branch  = (op == 7'h63);
    e.jump    = (op inside {7'h6F, 7'h67});
    e.illegal = !known;
  endfunction

  function automatic logic m_imm();
    return 1'b0;
  endfunction

  function automatic logic [2:0] m_imm_src();
    logic [2:0] imm; ex_t d;
    mdec(i_instr, imm, d);
    return imm;
  endfunction

  // Hazard: the instruction in ID reads a register a load in EX is writing.
  function automatic logic m_stall();
    logic [2:0] imm; ex_t d;
    mdec(i_instr, imm, d);
    return i_id_valid && m_ex.valid && m_ex.mem_ren && (m_ex.rd != 5'd0) &&
           (d.rs1 == m_ex.rd || d.rs2 == m_ex.rd) && !i_flush;
  endfunction

  // Advance one clock and move the model along with the DUT.
  task automatic step();
    logic [2:0] imm; ex_t d, nx; bit st, ill;
    mdec(i_instr, imm, d);
    st = m_stall();
    nx = '0;
    if (!i_flush && !st) begin
      nx = d;
      if (!i_id_valid) begin
        nx.valid = 0; nx.reg_wen = 0; nx.mem_ren = 0; nx.mem_wen = 0;
        nx.alu_imm = 0; nx.branch = 0; nx.jump = 0; nx.illegal = 0;
      end
    end
    ill = !i_flush && !st && i_id_valid && d.illegal;
    @(posedge i_clk);
    m_ex = nx;
    if (i_cnt_clr) begin
      m_sc = 0; m_ic = 0; m_sc2 = 0; m_ic2 = 0;
    end else begin
      if (st)  begin if (m_sc < 65535) m_sc++; if (m_sc2 < 3) m_sc2++; end
      if (ill) begin if (m_ic < 65535) m_ic++; if (m_ic2 < 3) m_ic2++; end
    end
    #1;
  endtask

  task automatic clear_cnts();
    i_instr = NOP; i_id_valid = 1'b0; i_flush = 1'b0; i_cnt_clr = 1'b1;
    step();
    i_cnt_clr = 1'b0;
  endtask

  task automatic test_reset();
    #12;
    total++;
    if (dut_ex !== '0) begin
      bad++; $display("FAIL reset_ex got=%h exp=0", dut_ex);
    end
    total++;
    if ({o_stall_cnt, o_illegal_cnt, w2_stall_cnt, w2_illegal_cnt} !== '0) begin
      bad++; $display("FAIL reset_cnt got=%h/%h exp=0", o_stall_cnt, o_illegal_cnt);
    end
    total++;
    if ({o_stall, o_imm_src} !== 4'b0111) begin
      bad++; $display("FAIL reset_comb stall/imm got=%b/%b exp=0/111", o_stall, o_imm_src);
    end
    @(negedge i_clk);
    i_rst_n = 1'b1;
    step();
  endtask

  task automatic test_format();
    clear_cnts();
    for (int i = 0; i < 6; i++) begin
      i_instr = fmt_ins[i]; i_id_valid = 1'b1;
      #1;
      total++;
      if (o_imm_src !== fmt_imm[i]) begin
        bad++; $display("FAIL fmt_imm[%0d] got=%b exp=%b", i, o_imm_src, fmt_imm[i]);
      end
      step();
      total++;
      if (dut_ex !== m_ex) begin
        bad++; $display("FAIL fmt_ex[%0d] got=%h exp=%h", i, dut_ex, m_ex);
      end
    end
    total++;
    if (o_ex_illegal !== 1'b1 || o_illegal_cnt !== 16'd1) begin
      bad++; $display("FAIL fmt_illegal got=%b cnt=%0d exp=1 cnt=1", o_ex_illegal, o_illegal_cnt);
    end
  endtask

  task automatic test_load_use();
    clear_cnts();
    i_instr = LW_X5; i_id_valid = 1'b1;
    step();
    i_instr = ADD_X6;
    #1;
    total++;
    if (o_stall !== 1'b1) begin bad++; $display("FAIL lu_stall got=%b exp=1", o_stall); end
    step();
    total++;
    if ({o_ex_valid, o_stall} !== 2'b00) begin
      bad++; $display("FAIL lu_bubble valid/stall got=%b/%b exp=0/0", o_ex_valid, o_stall);
    end
    step();
    total++;
    if ({o_ex_valid, o_ex_rd, o_ex_rs1, o_ex_rs2} !== {1'b1, 5'd6, 5'd5, 5'd2}) begin
      bad++; $display("FAIL lu_add got=%b/%0d/%0d/%0d exp=1/6/5/2",
                      o_ex_valid, o_ex_rd, o_ex_rs1, o_ex_rs2);
    end
    total++;
    if (o_stall_cnt !== 16'd1) begin bad++; $display("FAIL lu_cnt got=%0d exp=1", o_stall_cnt); end
  endtask

  task automatic test_no_false_hazard();
    logic [31:0] ld [3] = '{LW_X0, LW_X5, LW_X5};
    logic [31:0] us [3] = '{ADD_X0, LUI_X7, SW_X5};
    logic        ex [3] = '{1'b0, 1'b0, 1'b1};
    clear_cnts();
    for (int i = 0; i < 3; i++) begin
      i_instr = ld[i]; i_id_valid = 1'b1;
      step();
      i_instr = us[i];
      #1;
      total++;
      if (o_stall !== ex[i]) begin
        bad++; $display("FAIL nfh[%0d] stall got=%b exp=%b", i, o_stall, ex[i]);
      end
      step();
      i_id_valid = 1'b0;
      step();
    end
  endtask

  task automatic test_flush();
    clear_cnts();
    i_instr = LW_X5; i_id_valid = 1'b1;
    step();
    i_instr = ADD_X6; i_flush = 1'b1;
    #1;
    total++;
    if (o_stall !== 1'b0) begin bad++; $display("FAIL flush_stall got=%b exp=0", o_stall); end
    step();
    i_flush = 1'b0;
    total++;
    if (o_ex_valid !== 1'b0 || o_stall_cnt !== 16'd0) begin
      bad++; $display("FAIL flush_ex valid=%b cnt=%0d exp=0 cnt=0", o_ex_valid, o_stall_cnt);
    end
  endtask

  task automatic test_saturation();
    clear_cnts();
    repeat (5) begin
      i_instr = LW_X5; i_id_valid = 1'b1;
      step();
      i_instr = ADD_X6;
      step();
      step();
    end
    total++;
    if (w2_stall_cnt !== 2'd3 || o_stall_cnt !== 16'd5) begin
      bad++; $display("FAIL sat got=%0d/%0d exp=3/5", w2_stall_cnt, o_stall_cnt);
    end
    i_instr = LW_X5;
    step();
    i_instr = ADD_X6; i_cnt_clr = 1'b1;
    #1;
    total++;
    if (o_stall !== 1'b1) begin bad++; $display("FAIL clr_stall got=%b exp=1", o_stall); end
    step();
    i_cnt_clr = 1'b0;
    total++;
    if (w2_stall_cnt !== 2'd0 || o_stall_cnt !== 16'd0) begin
      bad++; $display("FAIL clr_cnt got=%0d/%0d exp=0/0", w2_stall_cnt, o_stall_cnt);
    end
  endtask

  task automatic test_async_reset();
    i_instr = LW_X5; i_id_valid = 1'b1;
    step();
    i_instr = ADD_X6;
    total++;
    if (o_ex_valid !== 1'b1 || o_ex_mem_ren !== 1'b1) begin
      bad++; $display("FAIL ar_pre valid/ren got=%b/%b exp=1/1", o_ex_valid, o_ex_mem_ren);
    end
    #2;
    i_rst_n = 1'b0;
    m_ex = '0; m_sc = 0; m_ic = 0; m_sc2 = 0; m_ic2 = 0;
    #1;
    total++;
    if (dut_ex !== '0 || o_stall_cnt !== 16'd0 || o_illegal_cnt !== 16'd0 || o_stall !== 1'b0) begin
      bad++; $display("FAIL ar_regs got ex=%h cnt=%0d/%0d stall=%b exp=0", dut_ex,
                      o_stall_cnt, o_illegal_cnt, o_stall);
    end
    @(negedge i_clk);
    i_rst_n = 1'b1;
    step();
    total++;
    if (o_ex_valid !== 1'b1 || o_ex_rd !== 5'd6) begin
      bad++; $display("FAIL ar_restart valid/rd got=%b/%0d exp=1/6", o_ex_valid, o_ex_rd);
    end
  endtask

  task automatic test_random();
    logic [31:0] ins;
    logic        exp_st;
    logic [2:0]  exp_imm;
    for (int c = 0; c < 400; c++) begin
      ins = $urandom;
      ins[6:0]   = rnd_ops[$urandom_range(0, 12)];
      ins[11:7]  = 5'($urandom_range(0, 3));
      ins[19:15] = 5'($urandom_range(0, 3));
      ins[24:20] = 5'($urandom_range(0, 3));
      i_instr    = ins;
      i_id_valid = ($urandom_range(0, 9) != 0);
      i_flush    = ($urandom_range(0, 9) == 0);
      i_cnt_clr  = ($urandom_range(0, 39) == 0);
      #1;
      exp_st  = m_stall();
      exp_imm = m_imm_src();
      total++;
      if ({o_stall, o_imm_src} !== {exp_st, exp_imm}) begin
        bad++; $display("FAIL rnd_comb c=%0d ins=%h got=%b/%b exp=%b/%b", c, ins,
                        o_stall, o_imm_src, exp_st, exp_imm);
      end
      step();
      total++;
      if (dut_ex !== m_ex || o_stall_cnt !== 16'(m_sc) || o_illegal_cnt !== 16'(m_ic) ||
          w2_stall_cnt !== 2'(m_sc2) || w2_illegal_cnt !== 2'(m_ic2)) begin
        bad++; $display("FAIL rnd_reg c=%0d got=%h %0d %0d %0d %0d exp=%h %0d %0d %0d %0d",
                        c, dut_ex, o_stall_cnt, o_illegal_cnt, w2_stall_cnt, w2_illegal_cnt,
                        m_ex, m_sc, m_ic, m_sc2, m_ic2);
      end
    end
    i_flush = 1'b0; i_cnt_clr = 1'b0;
  endtask

  initial begin
    test_reset();
    test_format();
    test_load_use();
    test_no_false_hazard();
    test_flush();
    test_saturation();
    test_async_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
